interlock_ctrl: RTL and testbench
=================================

// Module: interlock_ctrl
// PURPOSE
//  N-door interlock (airlock) controller; successor to the fixed two-door FSM/timer/state_change path.
//  Takes raw button levels per door plus a panic button and grants at most one door open at a time.
//  Queues pending requests and serves them round-robin, with per-phase second timers and a panic override.
//  Feeds LED/7-seg output logic with per-door state, countdown and status.
// PARAMETERS
//  N_DOORS        3           number of doors, >=2
//  TICKS_PER_SEC  50_000_000  clk cycles per second tick (set small in simulation)
//  MOVE_SEC       3           seconds a door spends OPENING or CLOSING, >=1
//  OPEN_SEC       5           seconds a door is held OPEN, >=1
//  SEC_W          4           countdown width; must hold max(MOVE_SEC,OPEN_SEC)
// PORTS
//  clk           in   1          system clock (PLL output)
//  rst_n         in   1          asynchronous active-low reset
//  btn_level     in   N_DOORS    raw button levels, one per door, asynchronous
//  panic_level   in   1          raw panic button level, asynchronous
//  door_state    out  2*N_DOORS  per door {00 CLOSED, 01 OPENING, 10 OPEN, 11 CLOSING}; door i at [2i+1:2i]
//  pending       out  N_DOORS    queued requests not yet served
//  active_door   out  IDX_W      index of granted door; IDX_W = max(1,$clog2(N_DOORS))
//  sec_left      out  SEC_W      seconds remaining in current timed phase; 0 in IDLE/PANIC
//  panic_active  out  1          high while in PANIC
// BEHAVIOUR
//  Reset (async): door_state all CLOSED, pending 0, active_door 0, sec_left 0, panic_active 0,
//   round-robin pointer 0, prescaler 0, FSM IDLE. Reset mid-motion drops doors to CLOSED at once.
//  Inputs: each level goes through a 2-FF synchroniser, then rising-edge detection (1-cycle tick).
//   A tick is visible in state/pending 3 clk after the sampled rising edge. Held levels produce one tick only.
//  Prescaler: counts 0..TICKS_PER_SEC-1 and emits sec_tick on wrap. Cleared on every FSM state entry.
//  FSM (global) states: IDLE, OPENING, OPEN, CLOSING, PANIC, ALL_CLOSING.
//   IDLE: if pending!=0, grant the first set bit at or after rr_ptr (wrapping), then enter OPENING.
//    On grant: active_door=i, clear pending[i], sec_left=MOVE_SEC, rr_ptr=(i+1) mod N_DOORS.
//   OPENING: sec_tick decrements sec_left; on the tick where sec_left==1, enter OPEN with sec_left=OPEN_SEC.
//   OPEN: same countdown, then CLOSING with sec_left=MOVE_SEC. A tick from active_door reloads OPEN_SEC (hold-open).
//   CLOSING: countdown to IDLE, door CLOSED. A tick from active_door reverses to OPENING with sec_left=MOVE_SEC.
//   Non-active door ticks in any non-panic state set pending[j]. A tick on an already-set bit is a no-op.
//    An active-door tick during OPENING is ignored and never sets its own pending bit.
//   Only active_door ever shows non-CLOSED outside PANIC/ALL_CLOSING (interlock invariant).
//  Panic: a panic tick in any non-PANIC state enters PANIC next cycle.
//   PANIC: all doors OPEN, pending cleared, sec_left 0, panic_active 1. Door ticks are ignored.
//   A second panic tick enters ALL_CLOSING: all doors CLOSING, sec_left=MOVE_SEC, countdown, then IDLE.
//   Door ticks during ALL_CLOSING set pending normally.
//  Simultaneous events: panic beats door ticks in the same cycle. Several door ticks in one cycle all set pending.
//   A door tick in the same cycle as the IDLE grant is kept in pending (unless it is the granted door).
//  Counters saturate at 0 and never wrap; sec_left is never loaded with 0 except in IDLE/PANIC.
// TESTING (N_DOORS=3, TICKS_PER_SEC=4, MOVE_SEC=2, OPEN_SEC=3)
//  Door 1 press from reset -> door_state[3:2]: 01 for 8 clk, 10 for 12 clk, 11 for 8 clk, then 00. active_door=1.
//  Press doors 0 and 2 in same cycle while IDLE (rr_ptr=0) -> door 0 served first, pending=3'b100, then door 2.
//  Door 0 OPEN; press door 0 with sec_left=1 -> sec_left reloads to 3; OPEN lasts 12 more clk.
//  Door 2 CLOSING; press door 2 -> OPENING with sec_left=2; door 1 press meanwhile -> pending[1]=1, door 1 stays 00.
//  Panic during OPENING -> door_state=6'b101010, pending=0, panic_active=1.
//   Second panic -> 6'b111111 for 8 clk, then all 00.
//  Assert rst_n=0 mid-OPEN -> all outputs 0 asynchronously; after release the next press is served normally.
//  Invariant check every cycle outside PANIC/ALL_CLOSING: at most one door non-CLOSED.

Source files
------------

// File: rtl/interlock_ctrl.sv
// N-door airlock interlock: synchronised button edges, round-robin grant of one door at a time,
// per-phase second countdowns and a two-press panic override (all open, then all close).
module interlock_ctrl #(
    parameter int N_DOORS       = 3,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int MOVE_SEC      = 3,
    parameter int OPEN_SEC      = 5,
    parameter int SEC_W         = 4,
    parameter int IDX_W         = (N_DOORS > 2) ? $clog2(N_DOORS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_DOORS-1:0]     btn_level,
    input  logic                   panic_level,
    output logic [2*N_DOORS-1:0]   door_state,
    output logic [N_DOORS-1:0]     pending,
    output logic [IDX_W-1:0]       active_door,
    output logic [SEC_W-1:0]       sec_left,
    output logic                   panic_active
);
    localparam int PS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [N_DOORS-1:0] ONE = {{(N_DOORS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_OPENING, S_OPEN, S_CLOSING, S_PANIC, S_ALL_CLOSING
    } state_t;

    // Panic rides along as the MSB of the synchroniser/edge-detect chain.
    logic [N_DOORS:0]     r_sync1, r_sync2, r_prev, r_tick;
    state_t               r_state, w_state_nxt;
    logic [N_DOORS-1:0]   r_pending, w_pend_nxt;
    logic [IDX_W-1:0]     r_active, w_act_nxt, r_rr, w_rr_nxt, w_grant;
    logic [SEC_W-1:0]     r_sec, w_sec_nxt;
    logic [PS_W-1:0]      r_ps;
    logic                 w_ps_clr, w_sec_tick, w_panic_tk, w_act_tk;
    logic [N_DOORS-1:0]   w_door_tk, w_act_oh, w_other_tk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_tick  <= '0;
        end else begin
            r_sync1 <= {panic_level, btn_level};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_tick  <= r_sync2 & ~r_prev;
        end
    end

    assign w_door_tk  = r_tick[N_DOORS-1:0];
    assign w_panic_tk = r_tick[N_DOORS];
    assign w_act_oh   = ONE << r_active;
    assign w_act_tk   = |(w_door_tk & w_act_oh);
    assign w_other_tk = w_door_tk & ~w_act_oh;
    assign w_sec_tick = (r_ps == PS_W'(TICKS_PER_SEC - 1));

    // First pending bit at or after rr_ptr; scanning backwards lets the nearest one win.
    always_comb begin
        w_grant = r_rr;
        for (int k = N_DOORS - 1; k >= 0; k--) begin
            if (r_pending[(int'(r_rr) + k) % N_DOORS])
                w_grant = IDX_W'((int'(r_rr) + k) % N_DOORS);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pending;
        w_act_nxt   = r_active;
        w_rr_nxt    = r_rr;
        w_sec_nxt   = r_sec;
        w_ps_clr    = 1'b0;
        if (w_panic_tk && r_state != S_PANIC) begin
            w_state_nxt = S_PANIC;
            w_pend_nxt  = '0;
            w_sec_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_pend_nxt = r_pending | w_door_tk;
                    if (|r_pending) begin
                        w_pend_nxt  = (r_pending | w_door_tk) & ~(ONE << w_grant);
                        w_act_nxt   = w_grant;
                        w_rr_nxt    = (w_grant == IDX_W'(N_DOORS - 1)) ? '0 : w_grant + 1'b1;
                        w_sec_nxt   = SEC_W'(MOVE_SEC);
                        w_state_nxt = S_OPENING;
                    end
                end
                S_OPENING: begin
                    w_pend_nxt = r_pending | w_other_tk;
                    if (w_sec_tick) begin
                        if (r_sec <= 1) begin
                            w_state_nxt = S_OPEN;
                            w_sec_nxt   = SEC_W'(OPEN_SEC);
                        end else w_sec_nxt = r_sec - 1'b1;
                    end
                end
                S_OPEN: begin
                    w_pend_nxt = r_pending | w_other_tk;
                    if (w_act_tk) begin
                        w_sec_nxt = SEC_W'(OPEN_SEC);
                        w_ps_clr  = 1'b1;
                    end else if (w_sec_tick) begin
                        if (r_sec <= 1) begin
                            w_state_nxt = S_CLOSING;
                            w_sec_nxt   = SEC_W'(MOVE_SEC);
                        end else w_sec_nxt = r_sec - 1'b1;
                    end
                end
                S_CLOSING: begin
                    w_pend_nxt = r_pending | w_other_tk;
                    if (w_act_tk) begin
                        w_state_nxt = S_OPENING;
                        w_sec_nxt   = SEC_W'(MOVE_SEC);
                    end else if (w_sec_tick) begin
                        if (r_sec <= 1) begin
                            w_state_nxt = S_IDLE;
                            w_sec_nxt   = '0;
                        end else w_sec_nxt = r_sec - 1'b1;
                    end
                end
                S_PANIC: begin
                    w_pend_nxt = '0;
                    w_sec_nxt  = '0;
                    if (w_panic_tk) begin
                        w_state_nxt = S_ALL_CLOSING;
                        w_sec_nxt   = SEC_W'(MOVE_SEC);
                    end
                end
                S_ALL_CLOSING: begin
                    w_pend_nxt = r_pending | w_door_tk;
                    if (w_sec_tick) begin
                        if (r_sec <= 1) begin
                            w_state_nxt = S_IDLE;
                            w_sec_nxt   = '0;
                        end else w_sec_nxt = r_sec - 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        if (w_state_nxt != r_state) w_ps_clr = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_active  <= '0;
            r_rr      <= '0;
            r_sec     <= '0;
            r_ps      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pend_nxt;
            r_active  <= w_act_nxt;
            r_rr      <= w_rr_nxt;
            r_sec     <= w_sec_nxt;
            if (w_ps_clr || w_sec_tick) r_ps <= '0;
            else                        r_ps <= r_ps + 1'b1;
        end
    end

    always_comb begin
        door_state = '0;
        for (int i = 0; i < N_DOORS; i++) begin
            case (r_state)
                S_OPENING:     if (IDX_W'(i) == r_active) door_state[2*i +: 2] = 2'b01;
                S_OPEN:        if (IDX_W'(i) == r_active) door_state[2*i +: 2] = 2'b10;
                S_CLOSING:     if (IDX_W'(i) == r_active) door_state[2*i +: 2] = 2'b11;
                S_PANIC:       door_state[2*i +: 2] = 2'b10;
                S_ALL_CLOSING: door_state[2*i +: 2] = 2'b11;
                default:       door_state[2*i +: 2] = 2'b00;
            endcase
        end
    end

    assign pending      = r_pending;
    assign active_door  = r_active;
    assign sec_left     = r_sec;
    assign panic_active = (r_state == S_PANIC);
endmodule

// File: tb/tb_interlock_ctrl.sv
// Directed bench for interlock_ctrl: phase lengths, round-robin order, hold-open, reversal,
// panic sequence, async reset and a per-cycle single-open-door invariant.
module tb_interlock_ctrl;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   btn_level = '0;
    logic           panic_level = 1'b0;
    logic [2*N-1:0] door_state;
    logic [N-1:0]   pending;
    logic [1:0]     active_door;
    logic [3:0]     sec_left;
    logic           panic_active;

    int n_tests = 0;
    int n_fail  = 0;
    bit inv_en  = 1'b0;

    interlock_ctrl #(
        .N_DOORS(N), .TICKS_PER_SEC(4), .MOVE_SEC(2), .OPEN_SEC(3), .SEC_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .panic_level(panic_level),
        .door_state(door_state), .pending(pending), .active_door(active_door),
        .sec_left(sec_left), .panic_active(panic_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive levels, then wait until the resulting tick has landed in the FSM.
    task automatic press(input logic [N-1:0] mask, input logic pnc);
        btn_level   = mask;
        panic_level = pnc;
        repeat (4) @(negedge clk);
        btn_level   = '0;
        panic_level = 1'b0;
    endtask

    // Count consecutive samples (starting with the current one) where door d shows v.
    task automatic run_len(input int d, input logic [1:0] v, output int n);
        n = 0;
        while (door_state[2*d +: 2] == v && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn_level = '0;
        panic_level = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (inv_en && !panic_active && door_state != 6'b111111) begin
            int nc;
            nc = 0;
            for (int i = 0; i < N; i++) if (door_state[2*i +: 2] != 2'b00) nc++;
            check("invariant", (nc <= 1), 1);
        end
    end

    initial begin
        int n;
        bit found;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_door", door_state, 0);
        check("rst_pend", pending, 0);
        check("rst_act", active_door, 0);
        check("rst_sec", sec_left, 0);
        check("rst_panic", panic_active, 0);
        rst_n = 1'b1;
        @(negedge clk);
        inv_en = 1'b1;

        // Single press of door 1: 8 / 12 / 8 clocks of OPENING / OPEN / CLOSING
        press(3'b010, 1'b0);
        check("t1_pend", pending, 3'b010);
        check("t1_door_pre", door_state, 0);
        @(negedge clk);
        check("t1_door_opening", door_state, 6'b000100);
        check("t1_act", active_door, 1);
        check("t1_sec_move", sec_left, 2);
        check("t1_pend_clr", pending, 0);
        run_len(1, 2'b01, n); check("t1_opening_len", n, 8);
        check("t1_sec_open", sec_left, 3);
        run_len(1, 2'b10, n); check("t1_open_len", n, 12);
        run_len(1, 2'b11, n); check("t1_closing_len", n, 8);
        check("t1_closed", door_state, 0);
        check("t1_sec_idle", sec_left, 0);

        // Doors 0 and 2 together from rr_ptr=0
        do_reset();
        press(3'b101, 1'b0);
        check("t2_pend_both", pending, 3'b101);
        @(negedge clk);
        check("t2_act0", active_door, 0);
        check("t2_pend_left", pending, 3'b100);
        check("t2_door0", door_state, 6'b000001);
        run_len(0, 2'b01, n);
        run_len(0, 2'b10, n);
        run_len(0, 2'b11, n);
        @(negedge clk);
        check("t2_act2", active_door, 2);
        check("t2_door2", door_state, 6'b010000);
        check("t2_pend_empty", pending, 0);

        // Door 2 closing: own press reverses, door 1 press is queued
        run_len(2, 2'b01, n);
        run_len(2, 2'b10, n);
        check("t3_closing", door_state, 6'b110000);
        press(3'b110, 1'b0);
        check("t3_reversed", door_state, 6'b010000);
        check("t3_sec", sec_left, 2);
        check("t3_pend1", pending, 3'b010);
        run_len(2, 2'b01, n); check("t3_reopen_len", n, 8);

        // Hold-open: press door 2 while sec_left==1
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (sec_left == 1 && door_state[5:4] == 2'b10) found = 1'b1;
            else @(negedge clk);
        end
        check("t4_wait_sec1", found, 1);
        press(3'b100, 1'b0);
        check("t4_reload", sec_left, 3);
        check("t4_still_open", door_state[5:4], 2'b10);
        run_len(2, 2'b10, n); check("t4_open_more", n, 12);
        run_len(2, 2'b11, n);
        @(negedge clk);
        check("t4_next_door1", active_door, 1);
        check("t4_door1_opening", door_state, 6'b000100);

        // Panic during OPENING, then second panic closes everything
        press(3'b000, 1'b1);
        check("t5_panic_doors", door_state, 6'b101010);
        check("t5_panic_pend", pending, 0);
        check("t5_panic_flag", panic_active, 1);
        check("t5_panic_sec", sec_left, 0);
        repeat (2) @(negedge clk);
        press(3'b000, 1'b1);
        check("t5_allclose", door_state, 6'b111111);
        check("t5_allclose_sec", sec_left, 2);
        check("t5_allclose_flag", panic_active, 0);
        run_len(0, 2'b11, n); check("t5_allclose_len", n, 8);
        check("t5_all_closed", door_state, 0);

        // Async reset mid-OPEN, then normal service
        press(3'b001, 1'b0);
        @(negedge clk);
        run_len(0, 2'b01, n);
        check("t6_open", door_state, 6'b000010);
        rst_n = 1'b0;
        #1;
        check("t6_rst_door", door_state, 0);
        check("t6_rst_sec", sec_left, 0);
        check("t6_rst_act", active_door, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        press(3'b100, 1'b0);
        check("t6_pend", pending, 3'b100);
        @(negedge clk);
        check("t6_act", active_door, 2);
        check("t6_door", door_state, 6'b010000);

        inv_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
